// File: rtl/cpc_bank_pkg.sv
// Shared constants and segment-mapping rules for the CPC RAM expansion bank controller.
package cpc_bank_pkg;

  typedef enum logic [2:0] {
    MODE_0 = 3'd0,
    MODE_1 = 3'd1,
    MODE_2 = 3'd2,
    MODE_3 = 3'd3,
    MODE_4 = 3'd4,
    MODE_5 = 3'd5,
    MODE_6 = 3'd6,
    MODE_7 = 3'd7
  } mode_t;

  // Gate Array port decode: adr[15:14] and the RAM-config command in data[7:6]
  localparam logic [1:0] GA_PORT_SEL = 2'b01;
  localparam logic [1:0] GA_CMD_RAM  = 2'b11;

  // Returns {is_exp, page[1:0]} for segment seg under the given mode.
  function automatic logic [2:0] map_segment(input mode_t mode, input logic [1:0] seg);
    logic [2:0] m;
    logic [2:0] mv;
    mv = mode;
    m  = {1'b0, seg};
    case (mode)
      MODE_0: m = {1'b0, seg};
      MODE_1: if (seg == 2'd3) m = {1'b1, 2'd3};
      MODE_2: m = {1'b1, seg};
      MODE_3: begin
        if (seg == 2'd1)      m = {1'b0, 2'd3};
        else if (seg == 2'd3) m = {1'b1, 2'd3};
      end
      default: if (seg == 2'd1) m = {1'b1, mv[1:0]};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/io_strobe_sync.sv
// Synchronises an asynchronous write strobe and emits a one-clock load pulse per assertion.
module io_strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic strobe,
  output logic load
);

  logic [STAGES-1:0] sync;
  logic              prev;
  logic              primed;

  // First clock after reset loads every stage from the live strobe, so a
  // strobe already held across reset release is not mistaken for a new edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync   <= '0;
      prev   <= 1'b0;
      primed <= 1'b0;
    end else if (!primed) begin
      sync   <= {STAGES{strobe}};
      prev   <= strobe;
      primed <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], strobe};
      prev <= sync[STAGES-1];
    end
  end

  // Qualified by the live strobe: the bus data is latched on this edge, and
  // pulses shorter than STAGES+1 clocks are rejected.
  assign load = primed & sync[STAGES-1] & ~prev & strobe;

endmodule

// File: rtl/cpc_bank_ctrl.sv
// 6128-style RAM bank controller: snoops Gate Array writes into cfg and decodes memory cycles.
module cpc_bank_ctrl
  import cpc_bank_pkg::*;
#(
  parameter int unsigned BLOCK_BITS  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic [15:0]           adr,
  input  logic [7:0]            data,
  input  logic                  iorq_b,
  input  logic                  wr_b,
  input  logic                  mreq_b,
  input  logic                  m1_b,
  input  logic                  rfsh_b,
  output logic                  ram_ce_b,
  output logic [BLOCK_BITS+1:0] ram_a,
  output logic                  ramdis,
  output logic [1:0]            int_page,
  output logic [BLOCK_BITS+2:0] cfg
);

  logic                  wstrobe;
  logic                  load;
  logic [1:0]            seg;
  logic [2:0]            tgt;
  logic [BLOCK_BITS-1:0] block;
  logic                  unused_adr;

  assign unused_adr = ^adr[13:0];

  assign wstrobe = ~iorq_b & ~wr_b & m1_b &
                   (adr[15:14] == GA_PORT_SEL) & (data[7:6] == GA_CMD_RAM);

  io_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .resetb (resetb),
    .strobe (wstrobe),
    .load   (load)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)   cfg <= '0;
    else if (load) cfg <= {data[3 +: BLOCK_BITS], data[2:0]};
  end

  always_comb begin
    seg      = adr[15:14];
    block    = cfg[BLOCK_BITS+2:3];
    tgt      = map_segment(mode_t'(cfg[2:0]), seg);
    ram_a    = {block, tgt[1:0]};
    ram_ce_b = 1'b1;
    ramdis   = 1'b0;
    int_page = tgt[1:0];
    if (tgt[2]) begin
      ram_ce_b = mreq_b | ~rfsh_b;
      ramdis   = ~mreq_b & rfsh_b;
      int_page = seg;
    end
  end

endmodule

// File: tb/tb_cpc_bank_ctrl.sv
// Scoreboard bench for cpc_bank_ctrl: directed plan cases plus randomized bus traffic.
module tb_cpc_bank_ctrl;

  localparam int unsigned BB = 3;
  localparam int unsigned SS = 2;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic [15:0]   adr = '0;
  logic [7:0]    data = '0;
  logic          iorq_b = 1'b1, wr_b = 1'b1, mreq_b = 1'b1, m1_b = 1'b1, rfsh_b = 1'b1;
  logic          ram_ce_b, ramdis;
  logic [BB+1:0] ram_a;
  logic [1:0]    int_page;
  logic [BB+2:0] cfg;

  cpc_bank_ctrl #(.BLOCK_BITS(BB), .SYNC_STAGES(SS)) dut (
    .clock(clock), .resetb(resetb), .adr(adr), .data(data),
    .iorq_b(iorq_b), .wr_b(wr_b), .mreq_b(mreq_b), .m1_b(m1_b), .rfsh_b(rfsh_b),
    .ram_ce_b(ram_ce_b), .ram_a(ram_a), .ramdis(ramdis), .int_page(int_page), .cfg(cfg)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [14:0] want;
  } chk_t;

  chk_t       sb[$];
  int         n_tests = 0, n_fail = 0, n_push = 0, n_pop = 0;
  event       sample_ev;
  logic [5:0] model_cfg = '0;

  // Expected {cfg, ram_ce_b, ram_a, ramdis, int_page} from the mapping table rules.
  function automatic logic [14:0] ref_out(input logic [5:0] c, input logic [15:0] a,
                                          input logic mq, input logic rf);
    int mode, s, page;
    bit ex;
    logic ce, dis;
    logic [1:0] pg, ip;
    mode = int'(c[2:0]);
    s    = int'(a[15:14]);
    ex   = 0;
    page = s;
    if (mode == 1 && s == 3) ex = 1;
    else if (mode == 2) ex = 1;
    else if (mode == 3) begin
      if (s == 1) page = 3;
      else if (s == 3) ex = 1;
    end else if (mode >= 4 && s == 1) begin
      ex = 1;
      page = mode - 4;
    end
    pg  = 2'(page);
    ce  = ex ? (mq | ~rf) : 1'b1;
    dis = ex & ~mq & rf;
    ip  = ex ? a[15:14] : pg;
    return {c, ce, c[5:3], pg, dis, ip};
  endfunction

  task automatic check(input string nm);
    chk_t e;
    #1;
    e.name = nm;
    e.want = ref_out(model_cfg, adr, mreq_b, rfsh_b);
    sb.push_back(e);
    n_push++;
    -> sample_ev;
  endtask

  always begin
    chk_t e;
    logic [14:0] got;
    @(sample_ev);
    got = {cfg, ram_ce_b, ram_a, ramdis, int_page};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h, nothing expected", got);
    end else begin
      e = sb.pop_front();
      n_pop++;
      if (got !== e.want) begin
        n_fail++;
        $display("FAIL %s at %0t: got {cfg,ce_b,ram_a,dis,ip}=%h want %h", e.name, $time, got, e.want);
      end
    end
  end

  task automatic release_bus();
    iorq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; mreq_b = 1'b1; rfsh_b = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      release_bus();
      check("idle");
    end
  endtask

  task automatic mem_read(input logic [15:0] a, input logic mq, input logic rf, input string nm);
    @(negedge clock);
    release_bus();
    adr = a; data = 8'($urandom); mreq_b = mq; rfsh_b = rf;
    check(nm);
  endtask

  // Strobe low for 'hold' rising edges; a valid write lands on the third edge.
  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                          input logic m1, input string nm);
    bit fires;
    fires = m1 && (a[15:14] == 2'b01) && (d[7:6] == 2'b11) && (hold >= 3);
    @(negedge clock);
    adr = a; data = d; iorq_b = 1'b0; wr_b = 1'b0; m1_b = m1; mreq_b = 1'b1; rfsh_b = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clock);
      if (fires && k == 3) model_cfg = {d[5:3], d[2:0]};
      check(nm);
    end
    release_bus();
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    adr = 16'hC000; mreq_b = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state");
    @(negedge clock);
    resetb = 1'b1; adr = '0; mreq_b = 1'b1;
    idle(2);

    io_write(16'h7F00, 8'hC2, 4, 1'b1, "wr_c2");
    mem_read(16'h4000, 1'b0, 1'b1, "rd_c2_4000");

    io_write(16'h7F00, 8'hFE, 4, 1'b1, "wr_fe");
    mem_read(16'h4000, 1'b0, 1'b1, "rd_fe_4000");
    mem_read(16'h8000, 1'b0, 1'b1, "rd_fe_8000");

    io_write(16'h7F00, 8'hC3, 4, 1'b1, "wr_c3");
    mem_read(16'h4000, 1'b0, 1'b1, "rd_c3_4000");
    mem_read(16'hC000, 1'b0, 1'b1, "rd_c3_c000");

    io_write(16'h7F00, 8'hC6, 4, 1'b0, "int_ack");
    io_write(16'h7F00, 8'h82, 4, 1'b1, "bad_data");
    io_write(16'hBF00, 8'hC6, 4, 1'b1, "bad_port");
    io_write(16'h7F00, 8'hC6, 2, 1'b1, "short_pulse");
    mem_read(16'h4000, 1'b0, 1'b1, "rd_after_ignored");

    io_write(16'h7F00, 8'hC2, 4, 1'b1, "wr_mode2");
    mem_read(16'hC000, 1'b0, 1'b0, "refresh_c000");
    mem_read(16'hC000, 1'b0, 1'b1, "rd_mode2_c000");

    // Reset in the middle of a held write strobe
    @(negedge clock);
    adr = 16'h7F00; data = 8'hC5; iorq_b = 1'b0; wr_b = 1'b0; m1_b = 1'b1; mreq_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 3) model_cfg = 6'h05;
      check("rst_pre_write");
    end
    @(negedge clock);
    resetb = 1'b0;
    model_cfg = '0;
    check("rst_mid_write");
    @(negedge clock);
    resetb = 1'b1;
    check("rst_release");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rst_strobe_held");
    end
    @(negedge clock);
    release_bus();
    check("rst_strobe_up");
    idle(2);
    io_write(16'h7F00, 8'hD1, 4, 1'b1, "rst_reload");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: io_write({2'b01, 14'($urandom)}, {2'b11, 6'($urandom)},
                       int'($urandom_range(2, 5)), 1'b1, "rnd_wr");
        2: io_write(16'($urandom), 8'($urandom), int'($urandom_range(3, 4)),
                    1'($urandom), "rnd_io");
        default: mem_read(16'($urandom), 1'($urandom), 1'($urandom), "rnd_rd");
      endcase
    end

    #5;
    n_tests++;
    if (sb.size() != 0 || n_pop != n_push) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left %0d, popped %0d of %0d", sb.size(), n_pop, n_push);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
